// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the axil_reg_slave register file.
// Address/data widths follow the slave's parameters.
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS 32-bit registers with independent AW/W
// acceptance, byte strobes, single outstanding write/read and a flat register export.
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axil_reg_slave_if.slave        s_axi,
    output logic [NUM_REGS*32-1:0] reg_out
);
    localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DW-1:0]     regs_r [NUM_REGS];
    logic              aw_held_r;
    logic              w_held_r;
    logic [IDX_W-1:0]  aw_idx_r;
    logic [DW-1:0]     wdata_r;
    logic [STRB_W-1:0] wstrb_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              rvalid_r;
    logic [1:0]        rresp_r;
    logic [DW-1:0]     rdata_r;

    logic              aw_fire_s;
    logic              w_fire_s;
    logic              ar_fire_s;
    logic              commit_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [DW-1:0]     wr_data_s;
    logic [STRB_W-1:0] wr_strb_s;
    logic [IDX_W-1:0]  ar_idx_s;
    logic [DW-1:0]     rd_data_s;
    logic              unused_s;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return (int'(idx) < NUM_REGS);
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0]     old_word,
                                                  input logic [DW-1:0]     new_word,
                                                  input logic [STRB_W-1:0] strb);
        logic [DW-1:0] merged;
        for (int b = 0; b < STRB_W; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

    assign s_axi.awready = !ARESET && !aw_held_r && !bvalid_r;
    assign s_axi.wready  = !ARESET && !w_held_r && !bvalid_r;
    assign s_axi.arready = !ARESET && !rvalid_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = bresp_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rresp   = rresp_r;
    assign s_axi.rdata   = rdata_r;

    assign unused_s = &{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Handshake decode, write operand selection (held latch vs live bus) and read mux
    always_comb begin
        aw_fire_s = s_axi.awvalid && s_axi.awready;
        w_fire_s  = s_axi.wvalid && s_axi.wready;
        ar_fire_s = s_axi.arvalid && s_axi.arready;
        commit_s  = (aw_held_r || aw_fire_s) && (w_held_r || w_fire_s);
        wr_idx_s  = aw_held_r ? aw_idx_r : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        wr_data_s = w_held_r ? wdata_r : s_axi.wdata;
        wr_strb_s = w_held_r ? wstrb_r : s_axi.wstrb;
        ar_idx_s  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
        // Out-of-range indices match no register, so the read word falls back to zero
        rd_data_s = {DW{1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            rd_data_s = rd_data_s | ((ar_idx_s == IDX_W'(k)) ? regs_r[k] : {DW{1'b0}});
        end
    end

    // Write channel: AW/W latches, register commit and B response
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_idx_r  <= {IDX_W{1'b0}};
            wdata_r   <= {DW{1'b0}};
            wstrb_r   <= {STRB_W{1'b0}};
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= {DW{1'b0}};
            end
        end else begin
            if (commit_s) begin
                aw_held_r <= 1'b0;
                w_held_r  <= 1'b0;
                bvalid_r  <= 1'b1;
                bresp_r   <= in_range(wr_idx_s) ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (wr_idx_s == IDX_W'(k)) begin
                        regs_r[k] <= merge_bytes(regs_r[k], wr_data_s, wr_strb_s);
                    end
                end
            end else begin
                if (aw_fire_s) begin
                    aw_held_r <= 1'b1;
                    aw_idx_r  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_fire_s) begin
                    w_held_r <= 1'b1;
                    wdata_r  <= s_axi.wdata;
                    wstrb_r  <= s_axi.wstrb;
                end
                if (bvalid_r && s_axi.bready) begin
                    bvalid_r <= 1'b0;
                end
            end
        end
    end

    // Read channel: register the selected word on AR, hold it until R handshake
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= {DW{1'b0}};
        end else if (ar_fire_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= in_range(ar_idx_s) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_r && s_axi.rready) begin
            rvalid_r <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs_r[g];
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: stimulus pushes expected B/R responses into
// queues, an independent negedge monitor pops and compares on every handshake.
module tb_axil_reg_slave;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [NR*32-1:0]  reg_out;

    axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .s_axi(bus),
        .reg_out(reg_out)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic [1:0] b_q [$];
    rd_exp_t    r_q [$];
    logic [1:0] b_e;
    rd_exp_t    r_e;
    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every B and R handshake against queued expectations
    always @(negedge ACLK) begin
        if (!ARESET && bus.bvalid && bus.bready) begin
            if (b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b: got bresp %0h expected no response", bus.bresp);
            end else begin
                b_e = b_q.pop_front();
                check32("bresp", 32'(bus.bresp), 32'(b_e));
            end
        end
        if (!ARESET && bus.rvalid && bus.rready) begin
            if (r_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r: got rdata %08h expected no response", bus.rdata);
            end else begin
                r_e = r_q.pop_front();
                check32("rdata", bus.rdata, r_e.data);
                check32("rresp", 32'(bus.rresp), 32'(r_e.resp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake expected one within 50 cycles", name);
    endtask

    task automatic do_aw(input logic [AW-1:0] addr, input int delay);
        int n = 0;
        idle(delay);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        @(negedge ACLK);
        while (!bus.awready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) timeout_fail("aw_timeout");
        @(posedge ACLK);
        #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
        int n = 0;
        idle(delay);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        @(negedge ACLK);
        while (!bus.wready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) timeout_fail("w_timeout");
        @(posedge ACLK);
        #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int w_delay,
                             input logic [1:0] exp_resp);
        b_q.push_back(exp_resp);
        fork
            do_aw(addr, aw_delay);
            do_w(data, strb, w_delay);
        join
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        int n = 0;
        r_q.push_back('{data: exp_data, resp: exp_resp});
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        @(negedge ACLK);
        while (!bus.arready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 50) timeout_fail("ar_timeout");
        @(posedge ACLK);
        #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        #1;
        check32("b_queue_drained", 32'(b_q.size()), 32'd0);
        check32("r_queue_drained", 32'(r_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check32({tag, "_awready"}, 32'(bus.awready), 32'd0);
        check32({tag, "_wready"},  32'(bus.wready),  32'd0);
        check32({tag, "_arready"}, 32'(bus.arready), 32'd0);
        check32({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
        check32({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
        check128({tag, "_reg_out"}, reg_out, 128'h0);
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_idle_outputs("reset");
        check32("reset_rdata", bus.rdata, 32'h0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        idle(1);

        // Basic writes with AW and W together, then readback
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, OKAY);
        axi_write(5'h04, 32'h2, 4'hF, 0, 0, OKAY);
        axi_write(5'h08, 32'h3, 4'hF, 0, 0, OKAY);
        axi_write(5'h0C, 32'h4, 4'hF, 0, 0, OKAY);
        axi_read(5'h00, 32'h1, OKAY);
        axi_read(5'h04, 32'h2, OKAY);
        axi_read(5'h08, 32'h3, OKAY);
        axi_read(5'h0C, 32'h4, OKAY);
        check128("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);

        // W ahead of AW, then AW ahead of W
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, OKAY);
        check32("reg2_w_first", reg_out[95:64], 32'hDEADBEEF);
        axi_write(5'h04, 32'hCAFEF00D, 4'hF, 0, 5, OKAY);
        check32("reg1_aw_first", reg_out[63:32], 32'hCAFEF00D);
        axi_read(5'h08, 32'hDEADBEEF, OKAY);
        axi_read(5'h04, 32'hCAFEF00D, OKAY);
        axi_read(5'h09, 32'hDEADBEEF, OKAY);

        // Byte strobes and empty strobe
        axi_write(5'h00, 32'h11223344, 4'hF, 0, 0, OKAY);
        axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, OKAY);
        check32("reg0_strb", reg_out[31:0], 32'h11BB33DD);
        axi_write(5'h00, 32'hFFFFFFFF, 4'b0000, 0, 0, OKAY);
        check32("reg0_strb0", reg_out[31:0], 32'h11BB33DD);
        axi_read(5'h00, 32'h11BB33DD, OKAY);

        // Back-pressure on B
        idle(2);
        bus.bready = 1'b0;
        axi_write(5'h0C, 32'h12345678, 4'hF, 0, 0, OKAY);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check32("bp_bvalid", 32'(bus.bvalid), 32'd1);
            check32("bp_awready", 32'(bus.awready), 32'd0);
            check32("bp_wready", 32'(bus.wready), 32'd0);
        end
        @(posedge ACLK);
        #1;
        bus.bready = 1'b1;

        // Back-pressure on R
        bus.rready = 1'b0;
        axi_read(5'h0C, 32'h12345678, OKAY);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            check32("bp_rvalid", 32'(bus.rvalid), 32'd1);
            check32("bp_arready", 32'(bus.arready), 32'd0);
            check32("bp_rdata", bus.rdata, 32'h12345678);
        end
        @(posedge ACLK);
        #1;
        bus.rready = 1'b1;

        // Read and write to the same register on the same edge
        idle(2);
        fork
            axi_write(5'h08, 32'h0BADF00D, 4'hF, 0, 0, OKAY);
            axi_read(5'h08, 32'hDEADBEEF, OKAY);
        join
        check32("reg2_after_rw", reg_out[95:64], 32'h0BADF00D);

        // Out-of-range address
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, SLVERR);
        axi_read(5'h10, 32'h0, SLVERR);
        axi_read(5'h1F, 32'h0, SLVERR);
        check128("reg_out_oor", reg_out, 128'h12345678_0BADF00D_CAFEF00D_11BB33DD);
        drain();

        // Reset with a write half-issued
        idle(2);
        do_aw(5'h04, 0);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_idle_outputs("midreset");
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check32("post_reset_bvalid", 32'(bus.bvalid), 32'd0);
            check128("post_reset_reg_out", reg_out, 128'h0);
        end
        @(posedge ACLK);
        #1;
        axi_write(5'h04, 32'h5, 4'hF, 0, 0, OKAY);
        check128("reg_out_after_reset", reg_out, 128'h00000000_00000000_00000005_00000000);
        axi_read(5'h04, 32'h5, OKAY);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
